// File: rtl/next_pc_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// next_pc_sequencer_if : fetch-loop control and next-PC / stack-status bundle
// Revision 1.0
// ---------------------------------------------------------------------------
interface next_pc_sequencer_if #(
   parameter int W = 8
);
   logic [W-1:0] PC;
   logic         stall;
   logic         branch_taken;
   logic [W-1:0] branch_offset;
   logic         jump;
   logic         call;
   logic         ret;
   logic [W-1:0] jump_target;
   logic         clear_flags;
   logic [W-1:0] nextPC;
   logic         ras_empty;
   logic         ras_full;
   logic         ras_overflow;
   logic         ras_underflow;

   modport slave (
      input  PC, stall, branch_taken, branch_offset, jump, call, ret,
             jump_target, clear_flags,
      output nextPC, ras_empty, ras_full, ras_overflow, ras_underflow
   );

   modport master (
      output PC, stall, branch_taken, branch_offset, jump, call, ret,
             jump_target, clear_flags,
      input  nextPC, ras_empty, ras_full, ras_overflow, ras_underflow
   );
endinterface
`default_nettype wire

// File: rtl/next_pc_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// next_pc_sequencer : next-PC select with return-address stack; NPC_RAS_EN
// selects the RAS_DEPTH stack, otherwise a single link register is used.
// Revision 1.0
// ---------------------------------------------------------------------------
module next_pc_sequencer #(
   parameter int W         = 8,
   parameter int RAS_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  reset_n,
   next_pc_sequencer_if.slave    bus
);

   logic [W-1:0] pc_inc;
   logic [W-1:0] npc;
   logic [W-1:0] top_val;
   logic         empty_w;
   logic         full_w;
   logic         do_ret;
   logic         do_call;
   logic         ovf_q, ovf_d;
   logic         udf_q, udf_d;

   // ret outranks call, so a simultaneous call is dropped entirely
   assign do_ret  = !bus.stall && bus.ret;
   assign do_call = !bus.stall && bus.call && !bus.ret;

`ifdef NPC_RAS_EN
   localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
   localparam int CW = $clog2(RAS_DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [W-1:0]  stack_q [RAS_DEPTH];
   logic [W-1:0]  stack_d [RAS_DEPTH];
   logic [PW-1:0] top_q, top_d;
   logic [CW-1:0] count_q, count_d;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == DEPTH_C);
   assign top_val = stack_q[top_q];

   // Push writes one slot past top; when full that slot is the oldest entry
   always_comb begin
      stack_d = stack_q;
      top_d   = top_q;
      count_d = count_q;
      if (do_ret && !empty_w) begin
         top_d   = top_q - PW'(1);
         count_d = count_q - CW'(1);
      end else if (do_call) begin
         top_d          = top_q + PW'(1);
         stack_d[top_d] = pc_inc;
         if (!full_w) begin
            count_d = count_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            stack_q[i] <= '0;
         end
         top_q   <= '0;
         count_q <= '0;
      end else begin
         stack_q <= stack_d;
         top_q   <= top_d;
         count_q <= count_d;
      end
   end
`else
   logic [W-1:0] link_q, link_d;
   logic         valid_q, valid_d;
   logic         unused_ras_depth;

   assign unused_ras_depth = (RAS_DEPTH != 0);
   assign empty_w = !valid_q;
   assign full_w  = valid_q;
   assign top_val = link_q;

   always_comb begin
      link_d  = link_q;
      valid_d = valid_q;
      if (do_ret) begin
         valid_d = 1'b0;
      end else if (do_call) begin
         link_d  = pc_inc;
         valid_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         link_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         link_q  <= link_d;
         valid_q <= valid_d;
      end
   end
`endif

   always_comb begin
      pc_inc = bus.PC + W'(1);
      npc    = pc_inc;
      if (bus.stall) begin
         npc = bus.PC;
      end else if (bus.ret) begin
         npc = empty_w ? pc_inc : top_val;
      end else if (bus.call || bus.jump) begin
         npc = bus.jump_target;
      end else if (bus.branch_taken) begin
         npc = pc_inc + bus.branch_offset;
      end
   end

   // A new error event beats a same-cycle clear
   always_comb begin
      ovf_d = (ovf_q && !bus.clear_flags) || (do_call && full_w);
      udf_d = (udf_q && !bus.clear_flags) || (do_ret && empty_w);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ovf_q <= 1'b0;
         udf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         udf_q <= udf_d;
      end
   end

   assign bus.nextPC        = npc;
   assign bus.ras_empty     = empty_w;
   assign bus.ras_full      = full_w;
   assign bus.ras_overflow  = ovf_q;
   assign bus.ras_underflow = udf_q;

endmodule
`default_nettype wire
